// File: rtl/serial_subtractor_4bits.sv
// serial_subtractor_4bits
//   Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
//   An accepted start latches the operands. WIDTH shift cycles follow, then one DONE cycle.
//   All outputs come straight from flops.
// Ports
//   clk     in   1      clock, rising edge
//   rst     in   1      synchronous active-high reset, overrides everything
//   start   in   1      request, sampled only while idle
//   a       in   WIDTH  minuend, captured on accept
//   b       in   WIDTH  subtrahend, captured on accept
//   bin     in   1      borrow-in, captured on accept
//   busy    out  1      high from the cycle after accept through the done cycle
//   done    out  1      one-cycle pulse, result valid from this cycle on
//   diff    out  WIDTH  (a - b - bin) mod 2^WIDTH
//   borrow  out  1      1 iff a < b + bin (unsigned)
module serial_subtractor_4bits #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    count_q, count_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;

   logic             d_bit;
   logic             br_next;
   logic [WIDTH-1:0] res_next;

   // One full-subtractor slice on the current LSBs.
   always_comb begin
      d_bit    = a_q[0] ^ b_q[0] ^ br_q;
      br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      res_next = {d_bit, res_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      br_d     = br_q;
      count_d  = count_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               res_d   = '0;
               count_d = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            res_d   = res_next;
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            br_d    = br_next;
            count_d = count_q + CW'(1);
            // Outputs are only updated here so no partial result is ever visible.
            if (count_q == LAST) begin
               diff_d   = res_next;
               borrow_d = br_next;
               done_d   = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            // start is deliberately not looked at here; it is dropped, not queued.
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         count_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         br_q     <= br_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule
